// File: rtl/bnn_uart_pkg.sv
// Shared UART definitions for the BNN controller serial path (tx and rx).
// Holds the frame FSM state type, the idle line level and default timing.
package bnn_uart_pkg;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    localparam logic UART_IDLE_LEVEL      = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 868;
    localparam int   DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/bnn_uart_tx_fifo.sv
// Byte FIFO between the controller and the UART transmitter FSM.
// Ports: push/din write, pop/dout read (dout shows head), full/empty/count status.
module bnn_uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)
                cnt <= cnt + CNT_ONE;
            else if (do_pop && !do_push)
                cnt <= cnt - CNT_ONE;
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == CNT_FULL);
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/bnn_uart_tx.sv
// UART transmitter (8N1 default, LSB first) with CTS flow control and byte FIFO.
// Ports: data_in/data_valid/data_ready push side, cts pin in, tx line, busy, tx_done pulse.
module bnn_uart_tx
    import bnn_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic                 cts,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    uart_state_t          state, state_nx;
    logic [BW-1:0]        baud_cnt, baud_nx;
    logic [IW-1:0]        bit_idx, bit_nx;
    logic [DATA_BITS-1:0] shift_reg, shift_nx;
    logic                 tx_q, tx_nx;
    logic                 cts_q1, cts_s;

    logic                 fifo_push, fifo_pop;
    logic                 fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;
    logic [CW-1:0]        fifo_count;

    logic baud_end;
    logic start_ok;

    assign data_ready = !fifo_full;
    assign fifo_push  = data_valid && data_ready;
    assign baud_end   = (baud_cnt == BAUD_LAST);
    assign start_ok   = !fifo_empty && cts_s;

    bnn_uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (data_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State, datapath and registered line output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= UART_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_q      <= UART_IDLE_LEVEL;
            cts_q1    <= 1'b0;
            cts_s     <= 1'b0;
        end else begin
            state     <= state_nx;
            baud_cnt  <= baud_nx;
            bit_idx   <= bit_nx;
            shift_reg <= shift_nx;
            tx_q      <= tx_nx;
            cts_q1    <= cts;
            cts_s     <= cts_q1;
        end
    end

    // Next state; cts_s is only looked at on frame boundaries.
    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt + BAUD_ONE;
        bit_nx   = bit_idx;
        shift_nx = shift_reg;
        fifo_pop = 1'b0;
        unique case (state)
            UART_IDLE: begin
                baud_nx = '0;
                if (start_ok) begin
                    fifo_pop = 1'b1;
                    shift_nx = fifo_dout;
                    state_nx = UART_START;
                end
            end
            UART_START: begin
                if (baud_end) begin
                    baud_nx  = '0;
                    bit_nx   = '0;
                    state_nx = UART_DATA;
                end
            end
            UART_DATA: begin
                if (baud_end) begin
                    baud_nx  = '0;
                    shift_nx = shift_reg >> 1;
                    if (bit_idx == DATA_LAST) begin
                        bit_nx   = '0;
                        state_nx = UART_STOP;
                    end else begin
                        bit_nx = bit_idx + IDX_ONE;
                    end
                end
            end
            UART_STOP: begin
                if (baud_end) begin
                    baud_nx = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_nx = '0;
                        // Chain straight into the next frame when allowed.
                        if (start_ok) begin
                            fifo_pop = 1'b1;
                            shift_nx = fifo_dout;
                            state_nx = UART_START;
                        end else begin
                            state_nx = UART_IDLE;
                        end
                    end else begin
                        bit_nx = bit_idx + IDX_ONE;
                    end
                end
            end
            default: state_nx = UART_IDLE;
        endcase
    end

    // Outputs; tx is computed from the next state so the flop lines up with state.
    always_comb begin
        tx_nx = UART_IDLE_LEVEL;
        unique case (state_nx)
            UART_START: tx_nx = 1'b0;
            UART_DATA:  tx_nx = shift_nx[0];
            default:    tx_nx = UART_IDLE_LEVEL;
        endcase
        tx_done = (state == UART_STOP) && baud_end && (bit_idx == STOP_LAST);
        busy    = (state != UART_IDLE) || (fifo_count != '0);
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_bnn_uart_tx.sv
// Directed bench for bnn_uart_tx with CLKS_PER_BIT=4 and a mid-bit line monitor.
// Checks reset, framing, FIFO back-pressure, CTS gating and mid-frame reset.
module tb_bnn_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       cts;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    bit mon_abort = 1'b0;

    logic [9:0] rx_line[$];
    int         rx_start[$];

    bnn_uart_tx #(
        .CLKS_PER_BIT (4),
        .DATA_BITS    (8),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .cts        (cts),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    // Line monitor: frame cycle 0 is the first cycle with tx low,
    // each bit is sampled in cycle 2 of its 4-cycle period.
    initial begin
        logic [9:0] line;
        int         st;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                st = cyc;
                mon_abort = 1'b0;
                repeat (2) @(negedge clk);
                line[0] = tx;
                for (int k = 1; k < 10; k++) begin
                    repeat (4) @(negedge clk);
                    line[k] = tx;
                end
                @(negedge clk);
                if (!mon_abort) begin
                    rx_line.push_back(line);
                    rx_start.push_back(st);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k = 0;
        while (rx_line.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, rx_line.size(), n);
    endtask

    task automatic clear_rx();
        rx_line.delete();
        rx_start.delete();
    endtask

    initial begin
        int n;
        int m;
        int g;
        int k;
        int base_done;
        bit ok;

        // 1. Reset with a write pending.
        rst_n      = 1'b0;
        cts        = 1'b0;
        data_valid = 1'b1;
        data_in    = 8'h77;
        step(3);
        check("rst_tx", tx, 1);
        check("rst_ready", data_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        data_valid = 1'b0;
        rst_n      = 1'b1;
        step(2);
        check("rst_no_write", busy, 0);

        // 2. Single frame 0xA5.
        cts = 1'b1;
        step(3);
        clear_rx();
        base_done  = done_cnt;
        n          = cyc;
        data_in    = 8'hA5;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step();
        check("a5_tx_low_n2", tx, 0);
        wait_frames(1, 100, "a5_frames");
        if (rx_line.size() > 0) begin
            check("a5_start_cyc", rx_start[0], n + 2);
            check("a5_line", rx_line[0], 10'b1101001010);
        end
        step(2);
        check("a5_done_cnt", done_cnt - base_done, 1);
        if (rx_start.size() > 0)
            check("a5_done_cyc", done_cyc, rx_start[0] + 39);
        check("a5_idle_busy", busy, 0);

        // 3. Five back-to-back bytes; one pops in the first IDLE cycle,
        //    so five accepts fit and the FIFO is full the cycle after.
        clear_rx();
        base_done = done_cnt;
        n = cyc;
        k = 0;
        g = 0;
        while (k < 5 && g < 20) begin
            data_in    = 8'(k + 1);
            data_valid = 1'b1;
            if (data_ready) k++;
            step();
            g++;
        end
        data_valid = 1'b0;
        check("b2b_accept_cycles", g, 5);
        check("b2b_ready_low", data_ready, 0);
        wait_frames(5, 300, "b2b_frames");
        if (rx_line.size() == 5) begin
            check("b2b_first_start", rx_start[0], n + 2);
            for (int i = 0; i < 5; i++)
                check($sformatf("b2b_byte%0d", i), rx_line[i][8:1], i + 1);
            for (int i = 0; i < 4; i++)
                check($sformatf("b2b_gap%0d", i),
                      rx_start[i+1] - rx_start[i], 40);
            for (int i = 0; i < 5; i++)
                check($sformatf("b2b_framing%0d", i),
                      {rx_line[i][9], rx_line[i][0]}, 2'b10);
        end
        step(2);
        check("b2b_done_cnt", done_cnt - base_done, 5);
        check("b2b_ready_back", data_ready, 1);
        check("b2b_idle_busy", busy, 0);

        // 4. CTS held off, then granted.
        cts = 1'b0;
        step(3);
        clear_rx();
        data_in    = 8'h3C;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        ok = 1'b1;
        repeat (100) begin
            if (tx !== 1'b1 || busy !== 1'b1) ok = 1'b0;
            step();
        end
        check("cts_hold_line", ok, 1);
        check("cts_hold_noframe", rx_line.size(), 0);
        m   = cyc;
        cts = 1'b1;
        wait_frames(1, 100, "cts_frames");
        if (rx_line.size() > 0) begin
            check("cts_start_lat", rx_start[0], m + 3);
            check("cts_byte", rx_line[0][8:1], 8'h3C);
        end
        step(2);

        // 5. CTS drops mid-frame.
        clear_rx();
        n          = cyc;
        data_in    = 8'h55;
        data_valid = 1'b1;
        step();
        data_in = 8'h66;
        step();
        data_valid = 1'b0;
        while (cyc < n + 16) step();
        cts = 1'b0;
        wait_frames(1, 100, "mid_first");
        step(60);
        check("mid_held", rx_line.size(), 1);
        check("mid_busy", busy, 1);
        check("mid_tx_idle", tx, 1);
        m   = cyc;
        cts = 1'b1;
        wait_frames(2, 100, "mid_frames");
        if (rx_line.size() == 2) begin
            check("mid_byte0", rx_line[0][8:1], 8'h55);
            check("mid_byte1", rx_line[1][8:1], 8'h66);
            check("mid_start1", rx_start[1], m + 3);
        end
        step(2);

        // 6. Reset during data bit 3 of 0xF0 with 0x0F queued.
        clear_rx();
        n          = cyc;
        data_in    = 8'hF0;
        data_valid = 1'b1;
        step();
        data_in = 8'h0F;
        step();
        data_valid = 1'b0;
        while (cyc < n + 2 + 17) step();
        check("rst6_tx_low_before", tx, 0);
        rst_n     = 1'b0;
        mon_abort = 1'b1;
        #1;
        check("rst6_tx_async", tx, 1);
        step();
        check("rst6_busy_in", busy, 0);
        rst_n = 1'b1;
        step(2);
        check("rst6_busy_after", busy, 0);
        ok = 1'b1;
        repeat (100) begin
            if (tx !== 1'b1) ok = 1'b0;
            step();
        end
        check("rst6_line_quiet", ok, 1);
        check("rst6_no_frame", rx_line.size(), 0);
        check("rst6_busy_end", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
